// File: rtl/bullet.sv
// -----------------------------------------------------------------------------
// bullet -- single-bullet projectile engine for one tank.
//
// Launches a bullet from the grid cell in front of the tank and advances it one
// cell every STEP_DIV frame ticks in the direction latched at launch. The bullet
// is retired when its next cell would leave the map, when the collision stage
// reports a hit, or on round reset (game_state == 2'b10). All outputs are
// registered.
//
// Optional feature macro: BULLET_COOLDOWN_EN
//   defined   -> a COOL state with an 8-bit counter blocks relaunch for
//                COOLDOWN ticks after any death.
//   undefined -> death returns straight to IDLE; COOLDOWN is unused.
//
// Parameters:
//   MAP_W     grid width in cells (legal x 0..MAP_W-1)
//   MAP_H     grid height in cells (legal y 0..MAP_H-1)
//   STEP_DIV  ticks per one-cell move, 1..15
//   COOLDOWN  reload ticks after death, 1..255 (cooldown build only)
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   tick                one-cycle frame strobe
//   fire                fire request level, sampled on tick in IDLE only
//   hit                 collision report, kills a flying bullet
//   game_state          2'b10 = round reset, outranks everything
//   tank_x/y/dir        tank position and facing (0 UP,1 DOWN,2 LEFT,3 RIGHT)
//   bullet_x/y/dir      bullet position and travel direction
//   bullet_active       bullet is live and drawable
//   fire_ack            one-cycle pulse coincident with a fresh launch
//
// Handshake: fire is a level, not a valid/ready pair. A request is consumed
// only on a tick in IDLE with an in-bounds spawn cell; otherwise it is dropped
// and never queued. fire_ack is the sole acknowledgement.
// -----------------------------------------------------------------------------
module bullet #(
    parameter int MAP_W    = 40,
    parameter int MAP_H    = 30,
    parameter int STEP_DIV = 2,
    parameter int COOLDOWN = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       fire,
    input  logic       hit,
    input  logic [1:0] game_state,
    input  logic [5:0] tank_x,
    input  logic [5:0] tank_y,
    input  logic [1:0] tank_dir,
    output logic [5:0] bullet_x,
    output logic [5:0] bullet_y,
    output logic [1:0] bullet_dir,
    output logic       bullet_active,
    output logic       fire_ack
);

    localparam logic [6:0] MAP_W7    = 7'(MAP_W);
    localparam logic [6:0] MAP_H7    = 7'(MAP_H);
    localparam logic [3:0] STEP_LAST = 4'(STEP_DIV - 1);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;

    // S_COOL is only ever entered in the cooldown build.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FLY  = 2'd1,
        S_COOL = 2'd2
    } state_t;

`ifdef BULLET_COOLDOWN_EN
    localparam logic [7:0] COOL_INIT = 8'(COOLDOWN);
`else
    logic [7:0] unused_cooldown;
    assign unused_cooldown = 8'(COOLDOWN);
`endif

    // True when the neighbour of (x,y) in direction dir lies on the map.
    // Decided purely by comparison so no coordinate ever wraps.
    function automatic logic cell_ok(input logic [5:0] x, input logic [5:0] y,
                                     input logic [1:0] dir);
        logic x_in;
        logic y_in;
        x_in = ({1'b0, x} < MAP_W7);
        y_in = ({1'b0, y} < MAP_H7);
        case (dir)
            DIR_UP:   return (y != 6'd0) && ({1'b0, y} <= MAP_H7) && x_in;
            DIR_DOWN: return (({1'b0, y} + 7'd1) < MAP_H7) && x_in;
            DIR_LEFT: return (x != 6'd0) && ({1'b0, x} <= MAP_W7) && y_in;
            default:  return (({1'b0, x} + 7'd1) < MAP_W7) && y_in;
        endcase
    endfunction

    function automatic logic [5:0] cell_x(input logic [5:0] x, input logic [1:0] dir);
        case (dir)
            DIR_LEFT: return x - 6'd1;
            2'd3:     return x + 6'd1;
            default:  return x;
        endcase
    endfunction

    function automatic logic [5:0] cell_y(input logic [5:0] y, input logic [1:0] dir);
        case (dir)
            DIR_UP:   return y - 6'd1;
            DIR_DOWN: return y + 6'd1;
            default:  return y;
        endcase
    endfunction

    state_t     state_q,  state_d;
    logic [5:0] bx_q,     bx_d;
    logic [5:0] by_q,     by_d;
    logic [1:0] dir_q,    dir_d;
    logic       active_q, active_d;
    logic       ack_q,    ack_d;
    logic [3:0] step_q,   step_d;
`ifdef BULLET_COOLDOWN_EN
    logic [7:0] cool_q,   cool_d;
`endif

    logic round_reset;
    logic spawn_ok;
    logic move_ok;
    logic launch;
    logic kill;
    logic move;

    assign round_reset = (game_state == 2'b10);
    assign spawn_ok    = cell_ok(tank_x, tank_y, tank_dir);
    assign move_ok     = cell_ok(bx_q, by_q, dir_q);

    // State register (and all datapath flops).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            bx_q     <= 6'd0;
            by_q     <= 6'd0;
            dir_q    <= 2'd0;
            active_q <= 1'b0;
            ack_q    <= 1'b0;
            step_q   <= 4'd0;
`ifdef BULLET_COOLDOWN_EN
            cool_q   <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
            dir_q    <= dir_d;
            active_q <= active_d;
            ack_q    <= ack_d;
            step_q   <= step_d;
`ifdef BULLET_COOLDOWN_EN
            cool_q   <= cool_d;
`endif
        end
    end

    // Next-state logic: decides launch / move / kill events and counters.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        launch  = 1'b0;
        kill    = 1'b0;
        move    = 1'b0;
`ifdef BULLET_COOLDOWN_EN
        cool_d  = cool_q;
`endif
        if (round_reset) begin
            state_d = S_IDLE;
            step_d  = 4'd0;
`ifdef BULLET_COOLDOWN_EN
            cool_d  = 8'd0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (tick && fire && spawn_ok) begin
                        launch  = 1'b1;
                        step_d  = 4'd0;
                        state_d = S_FLY;
                    end
                end
                S_FLY: begin
                    // hit wins over a move scheduled on the same cycle.
                    if (hit) begin
                        kill = 1'b1;
                    end else if (tick) begin
                        if (step_q == STEP_LAST) begin
                            step_d = 4'd0;
                            if (move_ok) begin
                                move = 1'b1;
                            end else begin
                                kill = 1'b1;
                            end
                        end else begin
                            step_d = step_q + 4'd1;
                        end
                    end
                    if (kill) begin
                        step_d  = 4'd0;
`ifdef BULLET_COOLDOWN_EN
                        state_d = S_COOL;
                        cool_d  = COOL_INIT;
`else
                        state_d = S_IDLE;
`endif
                    end
                end
`ifdef BULLET_COOLDOWN_EN
                S_COOL: begin
                    // Leave on the tick that takes the counter to zero.
                    if (tick) begin
                        cool_d = cool_q - 8'd1;
                        if (cool_q <= 8'd1) begin
                            cool_d  = 8'd0;
                            state_d = S_IDLE;
                        end
                    end
                end
`endif
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Output logic: registered outputs follow the events chosen above.
    // Position and direction hold through death and round reset.
    always_comb begin
        bx_d     = bx_q;
        by_d     = by_q;
        dir_d    = dir_q;
        active_d = active_q;
        ack_d    = 1'b0;
        if (round_reset) begin
            active_d = 1'b0;
        end else if (launch) begin
            bx_d     = cell_x(tank_x, tank_dir);
            by_d     = cell_y(tank_y, tank_dir);
            dir_d    = tank_dir;
            active_d = 1'b1;
            ack_d    = 1'b1;
        end else if (move) begin
            bx_d = cell_x(bx_q, dir_q);
            by_d = cell_y(by_q, dir_q);
        end else if (kill) begin
            active_d = 1'b0;
        end
    end

    assign bullet_x      = bx_q;
    assign bullet_y      = by_q;
    assign bullet_dir    = dir_q;
    assign bullet_active = active_q;
    assign fire_ack      = ack_q;

endmodule

// File: tb/tb_bullet.sv
module tb_bullet;

    localparam int MAP_W    = 40;
    localparam int MAP_H    = 30;
    localparam int STEP_DIV = 2;
    localparam int COOLDOWN = 3;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       fire;
    logic       hit;
    logic [1:0] game_state;
    logic [5:0] tank_x;
    logic [5:0] tank_y;
    logic [1:0] tank_dir;
    logic [5:0] bullet_x;
    logic [5:0] bullet_y;
    logic [1:0] bullet_dir;
    logic       bullet_active;
    logic       fire_ack;

    always #5 clk = ~clk;

    bullet #(
        .MAP_W(MAP_W), .MAP_H(MAP_H), .STEP_DIV(STEP_DIV), .COOLDOWN(COOLDOWN)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .fire(fire), .hit(hit),
        .game_state(game_state), .tank_x(tank_x), .tank_y(tank_y),
        .tank_dir(tank_dir), .bullet_x(bullet_x), .bullet_y(bullet_y),
        .bullet_dir(bullet_dir), .bullet_active(bullet_active),
        .fire_ack(fire_ack)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard: spawn cells of launches the model expects, {x, y}.
    logic [11:0] exp_q[$];

    // ---------------- reference model ----------------
    // Bullet described by its cell, age in ticks since launch and remaining
    // reload ticks; a move happens whenever the age is a multiple of STEP_DIV.
    bit         m_alive;
    bit         m_ack;
    int         m_x;
    int         m_y;
    logic [1:0] m_dir;
    int         m_ticks;
    int         m_cool;

    function automatic bit on_map(input int x, input int y);
        return (x >= 0) && (x < MAP_W) && (y >= 0) && (y < MAP_H);
    endfunction

    task automatic neighbour(input int x, input int y, input logic [1:0] d,
                             output int nx, output int ny);
        nx = x;
        ny = y;
        case (d)
            2'd0: ny = y - 1;
            2'd1: ny = y + 1;
            2'd2: nx = x - 1;
            default: nx = x + 1;
        endcase
    endtask

    task automatic model_kill();
        m_alive = 0;
`ifdef BULLET_COOLDOWN_EN
        m_cool = COOLDOWN;
`else
        m_cool = 0;
`endif
    endtask

    task automatic model_edge();
        int nx;
        int ny;
        m_ack = 0;
        if (rst) begin
            m_alive = 0; m_x = 0; m_y = 0; m_dir = 2'd0; m_ticks = 0; m_cool = 0;
            return;
        end
        if (game_state == 2'b10) begin
            m_alive = 0; m_ticks = 0; m_cool = 0;
            return;
        end
        if (m_alive) begin
            if (hit) begin
                model_kill();
            end else if (tick) begin
                m_ticks++;
                if (m_ticks % STEP_DIV == 0) begin
                    neighbour(m_x, m_y, m_dir, nx, ny);
                    if (on_map(nx, ny)) begin
                        m_x = nx;
                        m_y = ny;
                    end else begin
                        model_kill();
                    end
                end
            end
        end else if (m_cool > 0) begin
            if (tick) m_cool--;
        end else if (tick && fire) begin
            neighbour(int'(tank_x), int'(tank_y), tank_dir, nx, ny);
            if (on_map(nx, ny)) begin
                m_alive = 1; m_ack = 1; m_x = nx; m_y = ny;
                m_dir = tank_dir; m_ticks = 0;
                exp_q.push_back({6'(nx), 6'(ny)});
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, act, exp);
        end
    endtask

    task automatic compare_all();
        logic [11:0] want;
        chk("active", 12'(bullet_active), 12'(m_alive));
        chk("fire_ack", 12'(fire_ack), 12'(m_ack));
        chk("bullet_x", 12'(bullet_x), 12'(m_x));
        chk("bullet_y", 12'(bullet_y), 12'(m_y));
        chk("bullet_dir", 12'(bullet_dir), 12'(m_dir));
        if (fire_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_unexpected_ack observed=1 expected=0");
            end else begin
                want = exp_q.pop_front();
                chk("sb_spawn", {bullet_x, bullet_y}, want);
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic t, input logic f, input logic h, input logic [1:0] gs);
        tick = t;
        fire = f;
        hit = h;
        game_state = gs;
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic set_tank(input int x, input int y, input logic [1:0] d);
        tank_x = 6'(x);
        tank_y = 6'(y);
        tank_dir = d;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        tick = 1'b0; fire = 1'b0; hit = 1'b0; game_state = 2'b00;
        set_tank(10, 10, 2'd3);
        m_alive = 0; m_ack = 0; m_x = 0; m_y = 0; m_dir = 2'd0; m_ticks = 0; m_cool = 0;
        step(0, 0, 0, 2'b00);
        step(1, 1, 0, 2'b00);
        rst = 1'b0;
        chk("reset_active", 12'(bullet_active), 12'd0);
        chk("reset_xy", {bullet_x, bullet_y}, 12'd0);

        // Launch from (10,10) facing RIGHT.
        step(1, 1, 0, 2'b00);
        chk("launch_xy", {bullet_x, bullet_y}, {6'd11, 6'd10});
        chk("launch_ack", 12'(fire_ack), 12'd1);
        step(0, 1, 0, 2'b00);
        chk("ack_one_cycle", 12'(fire_ack), 12'd0);
        // Tank turns and moves: live bullet must not follow.
        set_tank(20, 5, 2'd0);
        step(1, 1, 0, 2'b00);
        step(1, 1, 0, 2'b00);
        chk("move1_x", 12'(bullet_x), 12'd12);
        step(1, 0, 0, 2'b00);
        step(1, 0, 0, 2'b00);
        chk("move2_x", 12'(bullet_x), 12'd13);
        chk("dir_latched", 12'(bullet_dir), 12'd3);
        step(0, 0, 1, 2'b00);
        chk("hit_kill", 12'(bullet_active), 12'd0);
        repeat (COOLDOWN + 1) step(1, 0, 0, 2'b00);

        // Spawn cell off the top edge.
        set_tank(5, 0, 2'd0);
        step(1, 1, 0, 2'b00);
        chk("edge_no_ack", 12'(fire_ack), 12'd0);
        chk("edge_inactive", 12'(bullet_active), 12'd0);

        // Wall exit on the right.
        set_tank(37, 4, 2'd3);
        step(1, 1, 0, 2'b00);
        chk("wall_launch_x", 12'(bullet_x), 12'd38);
        step(1, 0, 0, 2'b00);
        step(1, 0, 0, 2'b00);
        chk("wall_x39", 12'(bullet_x), 12'd39);
        step(1, 0, 0, 2'b00);
        chk("wall_still_live", 12'(bullet_active), 12'd1);
        step(1, 0, 0, 2'b00);
        chk("wall_dead", 12'(bullet_active), 12'd0);
        chk("wall_hold_x", 12'(bullet_x), 12'd39);
        repeat (COOLDOWN + 1) step(1, 0, 0, 2'b00);

        // Cooldown / relaunch after a hit.
        set_tank(10, 10, 2'd3);
        step(1, 1, 0, 2'b00);
        step(0, 0, 1, 2'b00);
`ifdef BULLET_COOLDOWN_EN
        repeat (COOLDOWN) begin
            step(1, 1, 0, 2'b00);
            chk("cool_blocked", 12'(fire_ack), 12'd0);
        end
`endif
        step(1, 1, 0, 2'b00);
        chk("relaunch_ack", 12'(fire_ack), 12'd1);

        // Hit and a move tick together: hit wins, position unchanged.
        step(1, 0, 0, 2'b00);
        step(1, 0, 1, 2'b00);
        chk("hit_prio_active", 12'(bullet_active), 12'd0);
        chk("hit_prio_x", 12'(bullet_x), 12'd11);
        repeat (COOLDOWN + 1) step(1, 0, 0, 2'b00);

        // Round reset mid-flight with fire held.
        step(1, 1, 0, 2'b00);
        step(1, 1, 0, 2'b10);
        chk("round_active", 12'(bullet_active), 12'd0);
        repeat (3) begin
            step(1, 1, 0, 2'b10);
            chk("round_no_ack", 12'(fire_ack), 12'd0);
        end
        step(1, 1, 0, 2'b00);
        chk("round_release_ack", 12'(fire_ack), 12'd1);

        // Synchronous reset mid-flight.
        step(1, 0, 0, 2'b00);
        rst = 1'b1;
        step(1, 0, 0, 2'b00);
        rst = 1'b0;
        chk("rst_mid_active", 12'(bullet_active), 12'd0);
        chk("rst_mid_xy", {bullet_x, bullet_y}, 12'd0);

        // Randomized phase with edge-biased tank positions.
        repeat (1500) begin
            int r;
            logic [1:0] gs;
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0)
                tank_x = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'(MAP_W - 1);
            else
                tank_x = 6'($urandom_range(0, MAP_W - 1));
            if ($urandom_range(0, 3) == 0)
                tank_y = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'(MAP_H - 1);
            else
                tank_y = 6'($urandom_range(0, MAP_H - 1));
            tank_dir = 2'($urandom_range(0, 3));
            r = $urandom_range(0, 39);
            gs = (r == 0) ? 2'b10 : (r == 1) ? 2'b11 : (r == 2) ? 2'b01 : 2'b00;
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 19) == 0), gs);
        end
        rst = 1'b0;

        chk("sb_drained", 12'(exp_q.size()), 12'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bullet.md
# bullet

Projectile engine for one tank. Sits directly downstream of the tank movement stage: it consumes the tank's registered grid position and facing direction, plus the per-frame direction-valid tick. It launches a single bullet from the cell in front of the tank, advances it across the 6-bit grid at a fixed tick rate, and retires it on wall exit, on an external hit, or on round reset. Position and status outputs feed the Game (collision) and VGA (drawing) stages.

## Interface
Parameters:
- MAP_W, 40, grid width in cells; legal x is 0..MAP_W-1.
- MAP_H, 30, grid height in cells; legal y is 0..MAP_H-1.
- STEP_DIV, 2, valid ticks per one-cell bullet move; range 1..15.
- COOLDOWN, 8, ticks of reload after a bullet dies; range 1..255; used only with BULLET_COOLDOWN_EN.

Ports:
- clk  in  1  system clock; the block has a single clock domain.
- rst  in  1  synchronous reset, active-high.
- tick  in  1  one-cycle frame pulse, the same strobe that drives tank movement.
- fire  in  1  fire request level; sampled only on tick.
- hit  in  1  Game reports a bullet collision; kills the bullet.
- game_state  in  2  value 2'b10 means round reset.
- tank_x  in  6  tank x position.
- tank_y  in  6  tank y position.
- tank_dir  in  2  tank facing: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT.
- bullet_x  out  6  bullet x position.
- bullet_y  out  6  bullet y position.
- bullet_dir  out  2  bullet travel direction.
- bullet_active  out  1  bullet is live and drawable.
- fire_ack  out  1  one-cycle pulse on launch.

## Operation
- States: IDLE, FLY, COOL. COOL exists only with BULLET_COOLDOWN_EN.
- Reset values: state IDLE; bullet_x, bullet_y, bullet_dir = 0; bullet_active = 0; fire_ack = 0; step and cooldown counters = 0.
- Spawn cell is the tank position offset by one cell in tank_dir:
  - UP: y-1
  - DOWN: y+1
  - LEFT: x-1
  - RIGHT: x+1
- IDLE, on tick with fire=1:
  - Spawn cell in bounds: load spawn position and tank_dir, set bullet_active, pulse fire_ack, clear step counter, go to FLY.
  - Spawn cell out of bounds (e.g. tank_y=0 with UP, or tank_x=MAP_W-1 with RIGHT): no launch, no fire_ack, stay IDLE.
- fire with no tick, or in any state other than IDLE: ignored. Requests are not queued.
- FLY, on each tick: step counter increments.
  - When the counter reaches STEP_DIV-1, it wraps to 0 and the bullet moves one cell in bullet_dir.
  - If the next cell is out of bounds, the bullet dies instead of moving.
- Bounds are checked before arithmetic; position never wraps through 0 or 63.
- Death: bullet_active=0; position and direction hold their last value. Next state is COOL with the counter loaded to COOLDOWN, or IDLE if the macro is absent.
- hit=1 in FLY kills the bullet that cycle. hit outranks a simultaneous move. hit outside FLY is ignored.
- game_state==2'b10 outranks everything:
  - Forces IDLE, bullet_active=0, fire_ack=0, counters cleared.
  - Fire is suppressed while it is held.
- Bullet direction is latched at launch; later tank turns or moves do not affect a live bullet.

## Timing
- All outputs are registered.
- Launch: tick and fire in cycle N give bullet_active=1 and fire_ack=1 in cycle N+1. fire_ack is low at N+2.
- First move: on the STEP_DIV-th tick after the launch tick. Moves then repeat every STEP_DIV ticks.
- Kill: hit, or an out-of-bounds move, in cycle N gives bullet_active=0 at N+1.
- Relaunch without the macro: a tick and fire in the cycle after death can launch.
- Relaunch with the macro: COOLDOWN ticks must elapse in COOL before IDLE. The counter decrements on tick and leaves COOL on the tick where it reaches 0.
- rst mid-flight: all outputs return to reset values on the next edge.

## Configuration
- BULLET_COOLDOWN_EN defined: COOL state and an 8-bit cooldown counter are built. After any death, including hit, launches are blocked for COOLDOWN ticks.
- BULLET_COOLDOWN_EN undefined: no COOL state; death returns to IDLE directly and the COOLDOWN parameter is unused.

## Test plan
- Launch: tank (10,10) RIGHT, STEP_DIV=2, fire+tick. Expect bullet (11,10) active and fire_ack for one cycle; x=12 after 2 more ticks, 13 after 4.
- Edge suppression: tank (5,0) UP, fire+tick. Expect no fire_ack and bullet_active stays 0.
- Wall exit: bullet at (38,4) RIGHT, MAP_W=40. Expect one move to 39, then active drops on the next step tick; x holds at 39.
- Hit priority: hit and a step tick in the same cycle. Expect active=0 the next cycle with the position unchanged.
- Cooldown: with macro and COOLDOWN=3, fire+tick on every tick after a kill. Expect no launch for 3 ticks, launch on the 4th. Without macro, launch on the first tick.
- Round reset: game_state=2'b10 mid-flight with fire held. Expect immediate IDLE, active=0 and no launch until game_state changes.
